// File: rtl/mano_timing_ctrl_pkg.sv
// Shared constants and types for the basic-computer timing controller.
// Optional feature macro used across this slice: MANO_TIMING_WDOG_EN.
package mano_ctrl_pkg;

    localparam int unsigned SC_W_DEFAULT = 3;

    // Timing-signal indices into t_dec
    localparam int unsigned T0 = 0;
    localparam int unsigned T1 = 1;
    localparam int unsigned T2 = 2;
    localparam int unsigned T3 = 3;
    localparam int unsigned T4 = 4;
    localparam int unsigned T5 = 5;
    localparam int unsigned T6 = 6;
    localparam int unsigned T7 = 7;

    // Last step of the interrupt cycle (RT2)
    localparam int unsigned RT_LAST = 2;

    typedef logic [SC_W_DEFAULT-1:0] sc_t;

endpackage

// File: rtl/mano_timing_ctrl_if.sv
// Control/status bundle of the timing controller.
// Adds wdog_err when MANO_TIMING_WDOG_EN is defined.
interface mano_timing_ctrl_if #(
    parameter int unsigned SC_W = mano_ctrl_pkg::SC_W_DEFAULT
);
    logic                   start;
    logic                   halt;
    logic                   sc_clr;
    logic                   ion;
    logic                   iof;
    logic                   fgi;
    logic                   fgo;
    logic [(1<<SC_W)-1:0]   t_dec;
    logic [SC_W-1:0]        sc;
    logic                   r;
    logic                   ien;
    logic                   running;
`ifdef MANO_TIMING_WDOG_EN
    logic                   wdog_err;

    modport master (
        output start, halt, sc_clr, ion, iof, fgi, fgo,
        input  t_dec, sc, r, ien, running, wdog_err
    );
    modport slave (
        input  start, halt, sc_clr, ion, iof, fgi, fgo,
        output t_dec, sc, r, ien, running, wdog_err
    );
`else
    modport master (
        output start, halt, sc_clr, ion, iof, fgi, fgo,
        input  t_dec, sc, r, ien, running
    );
    modport slave (
        input  start, halt, sc_clr, ion, iof, fgi, fgo,
        output t_dec, sc, r, ien, running
    );
`endif
endinterface

// File: rtl/mano_timing_ctrl_t_decoder.sv
// One-hot timing decoder: dec[sel] = en, all other bits zero.
module mano_t_decoder #(
    parameter int unsigned SC_W = 3
) (
    input  logic [SC_W-1:0]       sel,
    input  logic                  en,
    output logic [(1<<SC_W)-1:0]  dec
);

    // Combinational decode of the sequence count, gated by the run flag
    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/mano_timing_ctrl.sv
// Sequence counter, interrupt-cycle (RT0..RT2) and run/IEN control.
// Optional MANO_TIMING_WDOG_EN: a natural SC wrap sets sticky wdog_err
// and stops the machine.
module mano_timing_ctrl
    import mano_ctrl_pkg::*;
#(
    parameter int unsigned SC_W          = SC_W_DEFAULT,
    parameter bit          START_RUNNING = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mano_timing_ctrl_if.slave bus
);

    localparam logic [SC_W-1:0] RT2_SC = SC_W'(RT_LAST);

    logic [SC_W-1:0]       sc_q;
    logic                  r_q;
    logic                  ien_q;
    logic                  s_q;
    logic                  in_int;
    logic                  rt2;
    logic                  clr_ok;
    logic                  r_set;
    logic [(1<<SC_W)-1:0]  t_dec;
`ifdef MANO_TIMING_WDOG_EN
    logic                  wrap;
    logic                  wdog_q;
`endif

    mano_t_decoder #(.SC_W(SC_W)) u_dec (
        .sel (sc_q),
        .en  (s_q),
        .dec (t_dec)
    );

    // Step qualifiers derived from the current count and flags
    always_comb begin
        // r rises mid-instruction; that instruction's sc_clr must still end it
        // and lead into RT0, so sc_clr is only ignored inside RT0..RT2.
        in_int = r_q && (sc_q <= RT2_SC);
        rt2    = r_q && (sc_q == RT2_SC);
        clr_ok = bus.sc_clr && !in_int;
        r_set  = s_q && !r_q && (sc_q > RT2_SC) && ien_q && (bus.fgi || bus.fgo);
`ifdef MANO_TIMING_WDOG_EN
        wrap   = s_q && !rt2 && !clr_ok && (sc_q == '1);
`endif
    end

    // Sequence counter, R, IEN, S (and watchdog) state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q   <= '0;
            r_q    <= 1'b0;
            ien_q  <= 1'b0;
            s_q    <= START_RUNNING;
`ifdef MANO_TIMING_WDOG_EN
            wdog_q <= 1'b0;
`endif
        end else begin
            if (s_q) begin
                if (rt2) begin
                    sc_q  <= '0;
                    r_q   <= 1'b0;
                    ien_q <= 1'b0;
                end else begin
                    sc_q <= clr_ok ? '0 : sc_q + 1'b1;
                    if (r_set) begin
                        r_q <= 1'b1;
                    end
                    if (bus.iof) begin
                        ien_q <= 1'b0;
                    end else if (bus.ion) begin
                        ien_q <= 1'b1;
                    end
                end
            end

            if (bus.halt) begin
                s_q <= 1'b0;
`ifdef MANO_TIMING_WDOG_EN
            end else if (wrap) begin
                s_q <= 1'b0;
`endif
            end else if (bus.start) begin
                s_q <= 1'b1;
            end

`ifdef MANO_TIMING_WDOG_EN
            if (wrap) begin
                wdog_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.t_dec   = t_dec;
    assign bus.sc      = sc_q;
    assign bus.r       = r_q;
    assign bus.ien     = ien_q;
    assign bus.running = s_q;
`ifdef MANO_TIMING_WDOG_EN
    assign bus.wdog_err = wdog_q;
`endif

endmodule

// File: tb/tb_mano_timing_ctrl.sv
// Self-checking bench for mano_timing_ctrl (SC_W=3, START_RUNNING=0).
// Covers MANO_TIMING_WDOG_EN when the macro is defined for the build.
module tb_mano_timing_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state
    int m_sc;
    bit m_r, m_ien, m_s, m_wd;

    mano_timing_ctrl_if #(.SC_W(3)) bus ();

    mano_timing_ctrl #(.SC_W(3), .START_RUNNING(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        logic wd;
`ifdef MANO_TIMING_WDOG_EN
        wd = bus.wdog_err;
`else
        wd = 1'b0;
`endif
        return {bus.t_dec, bus.sc, bus.r, bus.ien, bus.running, wd};
    endfunction

    function automatic logic [14:0] expv();
        logic [7:0] td;
        td = m_s ? 8'(1 << m_sc) : 8'h00;
        return {td, 3'(m_sc), m_r, m_ien, m_s, m_wd};
    endfunction

    task automatic model_reset();
        m_sc = 0; m_r = 0; m_ien = 0; m_s = 0; m_wd = 0;
    endtask

    // Next state from the controller's rules, evaluated with pre-edge values
    task automatic model_step();
        int  nsc;
        bit  nr, nien, ns, in_int, ends_rt2, clr, wrapped;
        nsc = m_sc; nr = m_r; nien = m_ien; ns = m_s;
        wrapped = 0;
        if (m_s) begin
            in_int   = m_r && (m_sc <= 2);
            ends_rt2 = m_r && (m_sc == 2);
            clr      = bus.sc_clr && !in_int;
            if (ends_rt2) begin
                nsc = 0; nr = 0; nien = 0;
            end else begin
                nsc = clr ? 0 : (m_sc + 1) % N;
                wrapped = !clr && (m_sc == N - 1);
                if (!m_r && m_sc > 2 && m_ien && (bus.fgi || bus.fgo)) nr = 1;
                if (bus.iof) nien = 0;
                else if (bus.ion) nien = 1;
            end
        end
`ifndef MANO_TIMING_WDOG_EN
        wrapped = 0;
`endif
        if (bus.halt) ns = 0;
        else if (wrapped) ns = 0;
        else if (bus.start) ns = 1;
        if (wrapped) m_wd = 1;
        m_sc = nsc; m_r = nr; m_ien = nien; m_s = ns;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.halt = 0; bus.sc_clr = 0;
        bus.ion = 0; bus.iof = 0; bus.fgi = 0; bus.fgo = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        @(negedge clk);
        n_checks++;
        if (obs() !== 15'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs(), 15'h0000);
        end
        rst = 0;
        tick();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_walk();
        do_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL walk_model[%0d]: got %h expected %h", i, obs(), expv());
            end
            if (i < 8) begin
                n_checks++;
                if (bus.t_dec !== (8'h01 << i)) begin
                    n_fail++;
                    $display("FAIL walk_tdec[%0d]: got %h expected %h", i, bus.t_dec, 8'h01 << i);
                end
            end
            tick();
        end
`ifndef MANO_TIMING_WDOG_EN
        n_checks++;
        if (bus.t_dec !== 8'h02 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL walk_wrap: got t_dec=%h running=%b expected 02/1", bus.t_dec, bus.running);
        end
`endif
    endtask

    task automatic test_sc_clr();
        do_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 16 && m_sc != 4; k++) tick();
        bus.sc_clr = 1;
        tick();
        bus.sc_clr = 0;
        n_checks++;
        if (bus.sc !== 3'd0 || bus.t_dec !== 8'h01 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL sc_clr_at_4: got %h expected %h", obs(), expv());
        end
        for (int k = 0; k < 16 && m_sc != 3; k++) tick();
        bus.halt = 1; bus.sc_clr = 1;
        tick();
        bus.halt = 0; bus.sc_clr = 0;
        n_checks++;
        if (bus.running !== 1'b0 || bus.t_dec !== 8'h00 || bus.sc !== 3'd0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL halt_with_clr: got %h expected %h", obs(), expv());
        end
        tick();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL halted_hold: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_interrupt();
        int rises = 0;
        int rise_sc = -1;
        int instr = 0;
        logic [2:0] prev_sc;
        logic prev_r;
        do_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.fgi = 1;
        for (int k = 0; k < 40; k++) begin
            bus.ion    = (m_sc == 1 && instr == 0);
            bus.sc_clr = (m_sc == 5);
            if (m_sc == 5) instr++;
            prev_sc = bus.sc;
            prev_r  = bus.r;
            tick();
            if (!prev_r && bus.r === 1'b1) begin
                rises++;
                rise_sc = int'(prev_sc);
            end
            if (prev_r && bus.r === 1'b0) begin
                n_checks++;
                if (bus.sc !== 3'd0 || bus.ien !== 1'b0 || prev_sc !== 3'd2) begin
                    n_fail++;
                    $display("FAIL rt2_clear: got sc=%0d ien=%b from sc=%0d expected 0/0 from 2",
                             bus.sc, bus.ien, prev_sc);
                end
            end
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL intr_cycle[%0d]: got %h expected %h", k, obs(), expv());
            end
        end
        clear_inputs();
        n_checks++;
        if (rises != 1 || rise_sc != 3) begin
            n_fail++;
            $display("FAIL intr_entry: got rises=%0d at sc=%0d expected 1 at sc=3", rises, rise_sc);
        end
    endtask

    task automatic test_flag_window();
        do_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 30; k++) begin
            bus.ion    = (m_sc == 0);
            bus.fgi    = (m_sc <= 2);
            bus.sc_clr = (m_sc == 5);
            tick();
            n_checks++;
            if (bus.r !== 1'b0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL flag_window[%0d]: got %h expected %h", k, obs(), expv());
            end
        end
        bus.fgi = 0; bus.sc_clr = 0;
        bus.ion = 1; bus.iof = 1;
        tick();
        clear_inputs();
        n_checks++;
        if (bus.ien !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL ion_iof_both: got ien=%b expected 0", bus.ien);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.fgi = 1;
        for (int k = 0; k < 30 && !(m_r && m_sc == 1); k++) begin
            bus.ion    = (m_sc == 1);
            bus.sc_clr = (m_sc == 5);
            tick();
        end
        clear_inputs();
        n_checks++;
        if (obs() !== expv() || bus.r !== 1'b1 || bus.sc !== 3'd1) begin
            n_fail++;
            $display("FAIL reach_rt1: got %h expected %h", obs(), expv());
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if (bus.sc !== 3'd0 || bus.r !== 1'b0 || bus.ien !== 1'b0 || bus.t_dec !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got sc=%0d r=%b ien=%b t_dec=%h expected 0/0/0/00",
                     bus.sc, bus.r, bus.ien, bus.t_dec);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.start  = ($urandom % 8)  == 0;
            bus.halt   = ($urandom % 16) == 0;
            bus.sc_clr = ($urandom % 3)  == 0;
            bus.ion    = ($urandom % 6)  == 0;
            bus.iof    = ($urandom % 10) == 0;
            bus.fgi    = ($urandom % 4)  == 0;
            bus.fgo    = ($urandom % 5)  == 0;
            tick();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", k, obs(), expv());
            end
        end
        clear_inputs();
    endtask

`ifdef MANO_TIMING_WDOG_EN
    task automatic test_wdog();
        do_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (bus.wdog_err !== 1'b1 || bus.running !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL wdog_trip: got wdog=%b running=%b expected 1/0", bus.wdog_err, bus.running);
        end
        bus.start = 1;
        tick();
        bus.start = 0;
        n_checks++;
        if (bus.wdog_err !== 1'b1 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_sticky: got wdog=%b running=%b expected 1/1", bus.wdog_err, bus.running);
        end
        do_reset();
        n_checks++;
        if (bus.wdog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_rst: got %b expected 0", bus.wdog_err);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_walk();
        test_sc_clr();
        test_interrupt();
        test_flag_window();
        test_async_reset();
        test_random();
`ifdef MANO_TIMING_WDOG_EN
        test_wdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
